// File: rtl/bin_seq_ctrl.sv
// Per-bin SAT sequencer: load, decide/propagate/analyze/backtrack loop, write-back, result report.
// Define VAR_CTRL_PROP_WDOG_EN to build the PROP watchdog (result TIMEOUT after PROP_TIMEOUT cycles).
module bin_seq_ctrl #(
    parameter int unsigned NUM_VARS_A_BIN    = 8,
    parameter int unsigned NUM_CLAUSES_A_BIN = 24,
    parameter int unsigned WIDTH_LVL         = 10,
    parameter int unsigned PROP_SETTLE       = 2
`ifdef VAR_CTRL_PROP_WDOG_EN
  , parameter int unsigned PROP_TIMEOUT      = 255
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_bin_i,
    input  logic [9:0]                           bin_num_i,
    input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [1:0]                           result_o,
    input  logic                                 new_imply_i,
    input  logic                                 any_conflict_i,
    input  logic                                 unassigned_i,
    input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
    input  logic [9:0]                           bkt_bin_num_i,
    output logic                                 apply_load_o,
    output logic                                 wr_states_o,
    output logic                                 apply_analyze_o,
    output logic                                 apply_backtrack_o,
    output logic                                 apply_update_o,
    output logic                                 rd_states_o,
    output logic [$clog2(NUM_CLAUSES_A_BIN)-1:0] clause_addr_o,
    output logic [$clog2(NUM_VARS_A_BIN)-1:0]    var_addr_o,
    output logic                                 decide_o,
    output logic [WIDTH_LVL-1:0]                 decide_level_o,
    output logic [9:0]                           cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [9:0]                           bkt_bin_o
);
    localparam int unsigned CW = $clog2(NUM_CLAUSES_A_BIN);
    localparam int unsigned VW = $clog2(NUM_VARS_A_BIN);
    localparam int unsigned QW = $clog2(PROP_SETTLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_CLS, S_LOAD_VAR, S_PROP, S_DECIDE,
        S_ANALYZE, S_BKT, S_UPDATE_CLS, S_UPDATE_VAR, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        RES_SAT = 2'b00, RES_BKT_EXT = 2'b01, RES_UNSAT = 2'b10, RES_TIMEOUT = 2'b11
    } result_e;

    state_e               state_q;
    result_e              result_q;
    logic                 busy_q, done_q, load_q, wrs_q, ana_q, bkt_q, upd_q, rds_q, decide_q;
    logic                 ana_cnt_q, ovf_q;
    logic [CW-1:0]        caddr_q;
    logic [VW-1:0]        vaddr_q;
    logic [QW-1:0]        quiet_q, quiet_d;
    logic [WIDTH_LVL-1:0] cur_lvl_q, base_lvl_q, bkt_lvl_q, lvl_d;
    logic [9:0]           cur_bin_q, bkt_bin_q;
    logic                 settle;

    always_comb begin
        quiet_d = quiet_q + QW'(1);
        settle  = (quiet_d == QW'(PROP_SETTLE));
        lvl_d   = cur_lvl_q + WIDTH_LVL'(1);
    end

`ifdef VAR_CTRL_PROP_WDOG_EN
    localparam int unsigned TW = $clog2(PROP_TIMEOUT + 1);
    logic [TW-1:0] wdog_q, wdog_d;
    logic          wdog_hit;

    always_comb begin
        wdog_d   = wdog_q + TW'(1);
        wdog_hit = (wdog_d == TW'(PROP_TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (!rst || state_q != S_PROP) wdog_q <= '0;
        else                           wdog_q <= wdog_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            result_q   <= RES_SAT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            wrs_q      <= 1'b0;
            ana_q      <= 1'b0;
            bkt_q      <= 1'b0;
            upd_q      <= 1'b0;
            rds_q      <= 1'b0;
            decide_q   <= 1'b0;
            ana_cnt_q  <= 1'b0;
            ovf_q      <= 1'b0;
            caddr_q    <= '0;
            vaddr_q    <= '0;
            quiet_q    <= '0;
            cur_lvl_q  <= '0;
            base_lvl_q <= '0;
            bkt_lvl_q  <= '0;
            cur_bin_q  <= '0;
            bkt_bin_q  <= '0;
        end else begin
            // Quiet counter only lives within a PROP visit; clearing it elsewhere restarts each visit.
            if (state_q != S_PROP) quiet_q <= '0;
            case (state_q)
                S_IDLE: if (start_bin_i) begin
                    cur_bin_q  <= bin_num_i;
                    base_lvl_q <= base_lvl_i;
                    cur_lvl_q  <= base_lvl_i;
                    bkt_lvl_q  <= '0;
                    bkt_bin_q  <= '0;
                    ovf_q      <= 1'b0;
                    busy_q     <= 1'b1;
                    load_q     <= 1'b1;
                    caddr_q    <= '0;
                    state_q    <= S_LOAD_CLS;
                end
                S_LOAD_CLS, S_UPDATE_CLS: begin
                    if (caddr_q == CW'(NUM_CLAUSES_A_BIN - 1)) begin
                        caddr_q <= '0;
                        vaddr_q <= '0;
                        load_q  <= 1'b0;
                        upd_q   <= 1'b0;
                        wrs_q   <= (state_q == S_LOAD_CLS);
                        rds_q   <= (state_q == S_UPDATE_CLS);
                        state_q <= (state_q == S_LOAD_CLS) ? S_LOAD_VAR : S_UPDATE_VAR;
                    end else begin
                        caddr_q <= caddr_q + CW'(1);
                    end
                end
                S_LOAD_VAR, S_UPDATE_VAR: begin
                    if (vaddr_q == VW'(NUM_VARS_A_BIN - 1)) begin
                        vaddr_q <= '0;
                        wrs_q   <= 1'b0;
                        rds_q   <= 1'b0;
                        if (state_q == S_LOAD_VAR) begin
                            state_q <= S_PROP;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end else begin
                        vaddr_q <= vaddr_q + VW'(1);
                    end
                end
                S_PROP: begin
                    if (any_conflict_i) begin
                        ana_q     <= 1'b1;
                        ana_cnt_q <= 1'b0;
                        state_q   <= S_ANALYZE;
                    end else if (!new_imply_i && settle) begin
                        if (unassigned_i) begin
                            decide_q <= 1'b1;
                            if (cur_lvl_q == '1) ovf_q <= 1'b1;
                            else                 cur_lvl_q <= lvl_d;
                            state_q  <= S_DECIDE;
                        end else begin
                            result_q <= RES_SAT;
                            upd_q    <= 1'b1;
                            caddr_q  <= '0;
                            state_q  <= S_UPDATE_CLS;
                        end
`ifdef VAR_CTRL_PROP_WDOG_EN
                    end else if (wdog_hit) begin
                        result_q <= RES_TIMEOUT;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
`endif
                    end else begin
                        quiet_q <= new_imply_i ? '0 : quiet_d;
                    end
                end
                S_DECIDE: begin
                    decide_q <= 1'b0;
                    if (ovf_q) begin
                        result_q <= RES_UNSAT;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        state_q  <= S_PROP;
                    end
                end
                S_ANALYZE: begin
                    if (!ana_cnt_q) begin
                        ana_cnt_q <= 1'b1;
                    end else begin
                        ana_q     <= 1'b0;
                        bkt_lvl_q <= max_lvl_i;
                        bkt_bin_q <= bkt_bin_num_i;
                        if (cur_lvl_q == '0) begin
                            result_q <= RES_UNSAT;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else if (max_lvl_i > base_lvl_q) begin
                            bkt_q    <= 1'b1;
                            state_q  <= S_BKT;
                        end else begin
                            result_q <= RES_BKT_EXT;
                            upd_q    <= 1'b1;
                            caddr_q  <= '0;
                            state_q  <= S_UPDATE_CLS;
                        end
                    end
                end
                S_BKT: begin
                    bkt_q     <= 1'b0;
                    cur_lvl_q <= bkt_lvl_q;
                    state_q   <= S_PROP;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign result_o          = result_q;
    assign apply_load_o      = load_q;
    assign wr_states_o       = wrs_q;
    assign apply_analyze_o   = ana_q;
    assign apply_backtrack_o = bkt_q;
    assign apply_update_o    = upd_q;
    assign rd_states_o       = rds_q;
    assign clause_addr_o     = caddr_q;
    assign var_addr_o        = vaddr_q;
    assign decide_o          = decide_q;
    assign decide_level_o    = cur_lvl_q;
    assign cur_bin_num_o     = cur_bin_q;
    assign bkt_lvl_o         = bkt_lvl_q;
    assign bkt_bin_o         = bkt_bin_q;

endmodule

// File: tb/tb_bin_seq_ctrl.sv
// Directed bench for bin_seq_ctrl: load/update sequencing, SAT, decide, local/external backtrack,
// UNSAT, level overflow, mid-operation reset and (with VAR_CTRL_PROP_WDOG_EN) the PROP watchdog.
module tb_bin_seq_ctrl;
    localparam int unsigned NV = 8;
    localparam int unsigned NC = 24;
    localparam int unsigned WL = 10;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LOAD = 6'b100000;
    localparam logic [5:0] S_WR   = 6'b010000;
    localparam logic [5:0] S_ANA  = 6'b001000;
    localparam logic [5:0] S_BKT  = 6'b000100;
    localparam logic [5:0] S_UPD  = 6'b000010;
    localparam logic [5:0] S_RD   = 6'b000001;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_bin_i;
    logic [9:0]    bin_num_i;
    logic [WL-1:0] base_lvl_i;
    logic          busy_o, done_o;
    logic [1:0]    result_o;
    logic          new_imply_i, any_conflict_i, unassigned_i;
    logic [WL-1:0] max_lvl_i;
    logic [9:0]    bkt_bin_num_i;
    logic          apply_load_o, wr_states_o, apply_analyze_o, apply_backtrack_o;
    logic          apply_update_o, rd_states_o, decide_o;
    logic [4:0]    clause_addr_o;
    logic [2:0]    var_addr_o;
    logic [WL-1:0] decide_level_o, bkt_lvl_o;
    logic [9:0]    cur_bin_num_o, bkt_bin_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin_seq_ctrl #(
        .NUM_VARS_A_BIN(NV),
        .NUM_CLAUSES_A_BIN(NC),
        .WIDTH_LVL(WL),
        .PROP_SETTLE(2)
    ) dut (
        .clk(clk), .rst(rst),
        .start_bin_i(start_bin_i), .bin_num_i(bin_num_i), .base_lvl_i(base_lvl_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .new_imply_i(new_imply_i), .any_conflict_i(any_conflict_i), .unassigned_i(unassigned_i),
        .max_lvl_i(max_lvl_i), .bkt_bin_num_i(bkt_bin_num_i),
        .apply_load_o(apply_load_o), .wr_states_o(wr_states_o),
        .apply_analyze_o(apply_analyze_o), .apply_backtrack_o(apply_backtrack_o),
        .apply_update_o(apply_update_o), .rd_states_o(rd_states_o),
        .clause_addr_o(clause_addr_o), .var_addr_o(var_addr_o),
        .decide_o(decide_o), .decide_level_o(decide_level_o),
        .cur_bin_num_o(cur_bin_num_o), .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o)
    );

    function automatic logic [5:0] strb();
        return {apply_load_o, wr_states_o, apply_analyze_o, apply_backtrack_o, apply_update_o, rd_states_o};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({busy_o, done_o, result_o, strb(), clause_addr_o, var_addr_o, decide_o,
                    decide_level_o, cur_bin_num_o, bkt_lvl_o, bkt_bin_o});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        start_bin_i = 1'b0; new_imply_i = 1'b0; any_conflict_i = 1'b0; unassigned_i = 1'b0;
        max_lvl_i = '0; bkt_bin_num_i = '0; bin_num_i = '0; base_lvl_i = '0;
    endtask

    // Pulses start for one edge; returns in cycle 1 of the bin.
    task automatic start(input logic [9:0] bin, input logic [WL-1:0] base);
        bin_num_i = bin; base_lvl_i = base; start_bin_i = 1'b1;
        tick();
        start_bin_i = 1'b0;
        chk("start_busy", 64'(busy_o), 64'(1));
        chk("start_bin", 64'(cur_bin_num_o), 64'(bin));
        chk("start_lvl", 64'(decide_level_o), 64'(base));
    endtask

    task automatic xfer(input string tag, input logic [5:0] cs, input logic [5:0] vs);
        for (int i = 0; i < NC; i++) begin
            chk({tag, "_cls_strb"}, 64'(strb()), 64'(cs));
            chk({tag, "_cls_addr"}, 64'(clause_addr_o), 64'(i));
            tick();
        end
        for (int i = 0; i < NV; i++) begin
            chk({tag, "_var_strb"}, 64'(strb()), 64'(vs));
            chk({tag, "_var_addr"}, 64'(var_addr_o), 64'(i));
            tick();
        end
    endtask

    task automatic chk_done(input string tag, input logic [1:0] res);
        chk({tag, "_done"}, 64'({done_o, busy_o, result_o, strb()}), 64'({1'b1, 1'b0, res, S_NONE}));
        tick();
        chk({tag, "_done_drop"}, 64'({done_o, busy_o}), 64'(0));
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        repeat (3) tick();
        chk("reset_outs", all_outs(), 64'(0));
        rst = 1'b1;
        tick();

        // Pure SAT: load cycles 1..32, PROP 33..34, update 35..66, done 67
        start(10'h155, 10'd0);
        xfer("load", S_LOAD, S_WR);
        chk("sat_prop0", 64'(strb()), 64'(S_NONE));
        tick();
        chk("sat_prop1", 64'({strb(), decide_o}), 64'(0));
        tick();
        xfer("sat_upd", S_UPD, S_RD);
        chk_done("sat", 2'b00);

        // Decide with implications clearing the quiet counter, then SAT at level 4
        clear_inputs();
        unassigned_i = 1'b1;
        start(10'd2, 10'd3);
        xfer("dec_load", S_LOAD, S_WR);
        new_imply_i = 1'b1;
        tick();
        tick();
        new_imply_i = 1'b0;
        chk("dec_quiet0", 64'(decide_o), 64'(0));
        tick();
        chk("dec_quiet1", 64'(decide_o), 64'(0));
        tick();
        chk("dec_pulse", 64'({decide_o, decide_level_o, strb()}), 64'({1'b1, 10'd4, S_NONE}));
        unassigned_i = 1'b0;
        tick();
        chk("dec_pulse_end", 64'(decide_o), 64'(0));
        tick();
        chk("dec_prop", 64'(strb()), 64'(S_NONE));
        tick();
        xfer("dec_upd", S_UPD, S_RD);
        chk("dec_lvl_kept", 64'(decide_level_o), 64'(4));
        chk_done("dec", 2'b00);

        // Local backtrack: base 2, decide to 3 then 4, conflict, max_lvl 3
        clear_inputs();
        unassigned_i = 1'b1;
        start(10'd11, 10'd2);
        xfer("lb_load", S_LOAD, S_WR);
        tick(); tick();
        chk("lb_dec3", 64'({decide_o, decide_level_o}), 64'({1'b1, 10'd3}));
        tick(); tick(); tick();
        chk("lb_dec4", 64'({decide_o, decide_level_o}), 64'({1'b1, 10'd4}));
        any_conflict_i = 1'b1; max_lvl_i = 10'd3; bkt_bin_num_i = 10'd9;
        tick();
        chk("lb_prop", 64'(strb()), 64'(S_NONE));
        tick();
        any_conflict_i = 1'b0;
        chk("lb_ana0", 64'(strb()), 64'(S_ANA));
        tick();
        chk("lb_ana1", 64'(strb()), 64'(S_ANA));
        tick();
        chk("lb_bkt", 64'({strb(), bkt_lvl_o, decide_level_o}), 64'({S_BKT, 10'd3, 10'd4}));
        unassigned_i = 1'b0;
        tick();
        chk("lb_back_prop", 64'({strb(), decide_level_o}), 64'({S_NONE, 10'd3}));
        tick(); tick();
        xfer("lb_upd", S_UPD, S_RD);
        chk("lb_bkt_bin", 64'(bkt_bin_o), 64'(9));
        chk_done("lb", 2'b00);

        // External backtrack: conflict in the same cycle the settle would fire
        clear_inputs();
        start(10'd20, 10'd5);
        xfer("eb_load", S_LOAD, S_WR);
        tick();
        any_conflict_i = 1'b1; max_lvl_i = 10'd2; bkt_bin_num_i = 10'd7;
        tick();
        any_conflict_i = 1'b0;
        chk("eb_conflict_wins", 64'(strb()), 64'(S_ANA));
        tick();
        chk("eb_ana1", 64'(strb()), 64'(S_ANA));
        tick();
        chk("eb_bkt_vals", 64'({bkt_lvl_o, bkt_bin_o}), 64'({10'd2, 10'd7}));
        max_lvl_i = 10'd0; bkt_bin_num_i = 10'd0;
        xfer("eb_upd", S_UPD, S_RD);
        chk_done("eb", 2'b01);
        chk("eb_hold", 64'({bkt_lvl_o, bkt_bin_o}), 64'({10'd2, 10'd7}));

        // Level-0 conflict: UNSAT, no write-back
        clear_inputs();
        start(10'd1, 10'd0);
        xfer("un_load", S_LOAD, S_WR);
        any_conflict_i = 1'b1;
        tick();
        any_conflict_i = 1'b0;
        chk("un_ana0", 64'(strb()), 64'(S_ANA));
        tick();
        chk("un_ana1", 64'(strb()), 64'(S_ANA));
        tick();
        chk_done("un", 2'b10);

        // Decide at all-ones level saturates and reports UNSAT
        clear_inputs();
        unassigned_i = 1'b1;
        start(10'd4, 10'h3FF);
        xfer("ovf_load", S_LOAD, S_WR);
        tick(); tick();
        chk("ovf_dec", 64'({decide_o, decide_level_o}), 64'({1'b1, 10'h3FF}));
        tick();
        chk_done("ovf", 2'b10);

        // Start ignored while busy; reset during LOAD_VAR clears everything
        clear_inputs();
        start(10'd3, 10'd1);
        repeat (8) tick();
        bin_num_i = 10'h3FF; base_lvl_i = 10'd9; start_bin_i = 1'b1;
        tick();
        start_bin_i = 1'b0;
        chk("busy_ignore", 64'({cur_bin_num_o, decide_level_o, strb(), clause_addr_o}),
            64'({10'd3, 10'd1, S_LOAD, 5'd9}));
        repeat (19) tick();
        chk("rst_pre", 64'({strb(), var_addr_o}), 64'({S_WR, 3'd4}));
        rst = 1'b0;
        tick();
        chk("rst_mid", all_outs(), 64'(0));
        rst = 1'b1;
        tick();
        chk("rst_idle", 64'({busy_o, done_o, strb()}), 64'(0));

`ifdef VAR_CTRL_PROP_WDOG_EN
        clear_inputs();
        new_imply_i = 1'b1; unassigned_i = 1'b1;
        start(10'd6, 10'd1);
        xfer("wd_load", S_LOAD, S_WR);
        repeat (254) tick();
        chk("wd_pre", 64'(done_o), 64'(0));
        tick();
        chk_done("wd", 2'b11);
        clear_inputs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bin_seq_ctrl.md
# bin_seq_ctrl

Per-bin sequencer for the variable-cell array of the SAT engine. It loads one bin's clauses and variable states into the array, then runs the decide → propagate → analyze → backtrack loop at bin level. It writes the results back and reports SAT, UNSAT, or an out-of-bin backtrack request to the global scheduler. It owns every phase-control strobe that the variable and clause cells consume.

## Interface
- NUM_VARS_A_BIN, 8, variable cells per bin
- NUM_CLAUSES_A_BIN, 24, clause slots per bin
- WIDTH_LVL, 10, decision-level width
- PROP_SETTLE, 2, consecutive quiet cycles that end propagation
- PROP_TIMEOUT, 255, watchdog limit in cycles (macro only)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start_bin_i  in  1  pulse that starts a bin
- bin_num_i  in  10  bin number, latched on start
- base_lvl_i  in  WIDTH_LVL  decision level on entry, latched on start
- busy_o  out  1  high from start until done
- done_o  out  1  one-cycle completion pulse
- result_o  out  2  00 SAT, 01 BKT_EXT, 10 UNSAT, 11 TIMEOUT; valid with done_o
- new_imply_i  in  1  some cell gained an implication this cycle
- any_conflict_i  in  1  OR of the cells' find_conflict
- unassigned_i  in  1  at least one variable is still unassigned
- max_lvl_i  in  WIDTH_LVL  max-reduced var_level of all cells
- bkt_bin_num_i  in  10  OR-reduced bkt_bin_num of all cells
- apply_load_o, wr_states_o, apply_analyze_o, apply_backtrack_o, apply_update_o, rd_states_o  out  1 each  phase strobes
- clause_addr_o  out  $clog2(NUM_CLAUSES_A_BIN)  clause index during load/update
- var_addr_o  out  $clog2(NUM_VARS_A_BIN)  variable index during wr/rd states
- decide_o  out  1  pulse: the lowest unassigned variable takes the decision
- decide_level_o  out  WIDTH_LVL  current level
- cur_bin_num_o  out  10  latched bin number
- bkt_lvl_o  out  WIDTH_LVL  backtrack level
- bkt_bin_o  out  10  target bin for BKT_EXT

## Operation
- All outputs are registered. Reset values are 0 for every output. The FSM state is IDLE.
- IDLE: start_bin_i latches bin_num_i, base_lvl_i, and cur_lvl = base_lvl_i, then goes to LOAD_CLS. start_bin_i is ignored when busy_o=1.
- LOAD_CLS: apply_load_o=1 with clause_addr_o 0..NUM_CLAUSES_A_BIN-1, one per cycle. Then LOAD_VAR.
- LOAD_VAR: wr_states_o=1 with var_addr_o 0..NUM_VARS_A_BIN-1. Then PROP.
- PROP: a quiet counter clears whenever new_imply_i=1.
  - any_conflict_i=1 → ANALYZE. Conflict wins over a settle in the same cycle.
  - Counter reaches PROP_SETTLE with unassigned_i=1 → DECIDE.
  - Counter reaches PROP_SETTLE with unassigned_i=0 → UPDATE_CLS, result SAT.
- DECIDE: cur_lvl += 1, decide_o=1 for one cycle with decide_level_o = new cur_lvl, then PROP.
- ANALYZE: apply_analyze_o=1 for exactly 2 cycles. On the second cycle the block captures max_lvl_i into bkt_lvl and bkt_bin_num_i into bkt_bin. Decision, with priority:
  - cur_lvl==0 → DONE, UNSAT, no write-back.
  - bkt_lvl > base_lvl → BKT.
  - Otherwise → UPDATE_CLS, result BKT_EXT.
- BKT: apply_backtrack_o=1 for one cycle with bkt_lvl_o, cur_lvl ← bkt_lvl, then PROP.
- UPDATE_CLS: apply_update_o=1 with clause_addr_o 0..N-1. Then UPDATE_VAR: rd_states_o=1 with var_addr_o 0..M-1. Then DONE.
- DONE: done_o=1 and result_o valid for one cycle, busy_o drops, return to IDLE. bkt_lvl_o and bkt_bin_o hold until the next start.
- Level arithmetic is unsigned WIDTH_LVL. A DECIDE at the all-ones level saturates and forces result UNSAT. This is a documented overflow guard.

## Timing
- start at edge k → busy_o and apply_load_o high from cycle k+1.
- Load takes NUM_CLAUSES_A_BIN + NUM_VARS_A_BIN cycles. Update takes the same.
- Minimum PROP dwell is PROP_SETTLE cycles. ANALYZE is 2 cycles. BKT and DECIDE are 1 cycle each.
- The phase strobes are mutually exclusive in every cycle.
- Reset low mid-operation clears all outputs and returns the FSM to IDLE at the next edge. No done_o is issued.

## Configuration
- VAR_CTRL_PROP_WDOG_EN defined: a counter runs during each PROP visit. When it reaches PROP_TIMEOUT without a conflict or settle, the FSM goes to DONE with result 11 (TIMEOUT) and skips write-back.
- Macro undefined: no counter is built, and result 11 is never produced.

## Test plan
- Load sequencing: start at cycle 0, defaults → apply_load_o cycles 1–24 with addr 0–23; wr_states_o cycles 25–32 with addr 0–7; PROP from cycle 33.
- Pure SAT: new_imply_i low and unassigned_i=0 → after 2 quiet cycles, 24+8 update cycles, then done_o with result 00.
- Decide/propagate: unassigned_i=1, base 3 → decide_o with decide_level_o=4; after quiet and unassigned_i=0, result 00.
- Local backtrack: base 2, decide to level 4, conflict, max_lvl_i=3 → apply_backtrack_o one cycle with bkt_lvl_o=3, back in PROP at level 3.
- External backtrack: base 5, conflict, max_lvl_i=2, bkt_bin_num_i=7 → update phases, then done_o, result 01, bkt_lvl_o=2, bkt_bin_o=7.
- Level-0 conflict gives UNSAT (result 10, no update strobes). Reset asserted mid-LOAD_VAR → all strobes 0 the next cycle. With the watchdog enabled, new_imply_i held high gives TIMEOUT (result 11) after 255 cycles.
